ahb_mtx_out_stage3: RTL and testbench

AHB_MTX_OUT_STAGE3 -- requirements
Module: ahb_mtx_out_stage3

---
 rtl/ahb_mtx_out_stage3_pkg.sv | 45 ++++
 rtl/ahb_mtx_arb_rr3.sv | 90 +++++++++
 rtl/ahb_mtx_out_stage3.sv | 151 +++++++++++++++
 tb/tb_ahb_mtx_out_stage3.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mtx_out_stage3_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mtx_out_stage3_pkg
// Shared constants and helpers for the three-input AHB matrix output stage
// and its round-robin/lock arbiter.
//   NumPorts    : number of input ports feeding the output stage
//   MasterIdW   : width of HMASTERM
//   Trans*      : HTRANS encodings
//   rr_pick     : round-robin search starting at the highest-priority port
//   rr_next     : port following a given one, modulo NumPorts
// ---------------------------------------------------------------------------
package ahb_mtx_out_stage3_pkg;

    localparam int unsigned NumPorts  = 3;
    localparam int unsigned PortIdxW  = 2;
    localparam int unsigned MasterIdW = 4;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    localparam logic [2:0] BurstSingle = 3'b000;

    typedef logic [PortIdxW-1:0] port_idx_t;

    // Returns {found, port}: the first requesting port scanning upwards from ptr.
    function automatic logic [PortIdxW:0] rr_pick(input logic [NumPorts-1:0] req,
                                                  input port_idx_t           ptr);
        logic [PortIdxW:0] res;
        logic [31:0]       p;
        res = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            p = (32'(ptr) + i) % NumPorts;
            if (!res[PortIdxW] && req[p[PortIdxW-1:0]]) begin
                res = {1'b1, p[PortIdxW-1:0]};
            end
        end
        return res;
    endfunction

    function automatic port_idx_t rr_next(input port_idx_t p);
        return (p == port_idx_t'(NumPorts - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/ahb_mtx_arb_rr3.sv
// ---------------------------------------------------------------------------
// ahb_mtx_arb_rr3
// Registered round-robin arbiter with burst/lock hold for three input ports.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   ready         : HREADYMUXM; arbitration only advances when high
//   req           : per-port request (sel_opN)
//   trans         : per-port HTRANS, {port2, port1, port0}
//   burst         : per-port HBURST, {port2, port1, port0}
//   mastlock      : per-port HMASTLOCK
//   grant_valid   : a port has been granted since reset
//   grant         : granted (or parked) port
// ---------------------------------------------------------------------------
module ahb_mtx_arb_rr3
    import ahb_mtx_out_stage3_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       ready,
    input  logic [2:0] req,
    input  logic [5:0] trans,
    input  logic [8:0] burst,
    input  logic [2:0] mastlock,
    output logic       grant_valid,
    output logic [1:0] grant
);

    logic              valid_q, valid_d;
    port_idx_t         grant_q, grant_d;
    port_idx_t         ptr_q, ptr_d;     // highest-priority port for the next pick
    logic [1:0]        own_trans;
    logic [2:0]        own_burst;
    logic              own_lock;
    logic              hold;
    logic [PortIdxW:0] pick;

    always_comb begin
        own_trans = trans[1:0];
        own_burst = burst[2:0];
        own_lock  = mastlock[0];
        case (grant_q)
            2'd1: begin
                own_trans = trans[3:2];
                own_burst = burst[5:3];
                own_lock  = mastlock[1];
            end
            2'd2: begin
                own_trans = trans[5:4];
                own_burst = burst[8:6];
                own_lock  = mastlock[2];
            end
            default: ;
        endcase
    end

    // The first beat of a multi-beat burst also holds, otherwise the owner would
    // lose the bus between its NONSEQ and the following SEQ beats.
    assign hold = valid_q & ((own_trans == TransSeq) | (own_trans == TransBusy) |
                             ((own_trans == TransNonseq) & (own_burst != BurstSingle)) |
                             own_lock);

    assign pick = rr_pick(req, ptr_q);

    always_comb begin
        valid_d = valid_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        // No request leaves grant_q untouched, which parks on the last owner.
        if (ready && !hold && pick[PortIdxW]) begin
            valid_d = 1'b1;
            grant_d = pick[PortIdxW-1:0];
            ptr_d   = rr_next(pick[PortIdxW-1:0]);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_valid = valid_q;
    assign grant       = grant_q;

endmodule

// File: rtl/ahb_mtx_out_stage3.sv
// ---------------------------------------------------------------------------
// ahb_mtx_out_stage3
// AHB matrix output stage for three input ports: arbitrates, muxes the
// address phase of the granted port and the write data of the data-phase port.
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   sel/addr/trans/write/size/burst/prot/mastlock/wdata_opN : input port N
//   active_opN             : port N owns the output address phase
//   HSELM..HMASTLOCKM      : muxed address-phase signals to the slave
//   HWDATAM                : write data of the data-phase port
//   HREADYMUXM             : HREADY driven to the slave
//   HREADYOUTM             : slave HREADYOUT
// ---------------------------------------------------------------------------
module ahb_mtx_out_stage3
    import ahb_mtx_out_stage3_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        sel_op0,
    input  logic        sel_op1,
    input  logic        sel_op2,
    input  logic [31:0] addr_op0,
    input  logic [31:0] addr_op1,
    input  logic [31:0] addr_op2,
    input  logic [1:0]  trans_op0,
    input  logic [1:0]  trans_op1,
    input  logic [1:0]  trans_op2,
    input  logic        write_op0,
    input  logic        write_op1,
    input  logic        write_op2,
    input  logic [2:0]  size_op0,
    input  logic [2:0]  size_op1,
    input  logic [2:0]  size_op2,
    input  logic [2:0]  burst_op0,
    input  logic [2:0]  burst_op1,
    input  logic [2:0]  burst_op2,
    input  logic [3:0]  prot_op0,
    input  logic [3:0]  prot_op1,
    input  logic [3:0]  prot_op2,
    input  logic        mastlock_op0,
    input  logic        mastlock_op1,
    input  logic        mastlock_op2,
    input  logic [31:0] wdata_op0,
    input  logic [31:0] wdata_op1,
    input  logic [31:0] wdata_op2,
    output logic        active_op0,
    output logic        active_op1,
    output logic        active_op2,
    output logic        HSELM,
    output logic [31:0] HADDRM,
    output logic [1:0]  HTRANSM,
    output logic        HWRITEM,
    output logic [2:0]  HSIZEM,
    output logic [2:0]  HBURSTM,
    output logic [3:0]  HPROTM,
    output logic [3:0]  HMASTERM,
    output logic        HMASTLOCKM,
    output logic [31:0] HWDATAM,
    output logic        HREADYMUXM,
    input  logic        HREADYOUTM
);

    logic       grant_valid;
    logic [1:0] grant;
    logic       own_sel;
    logic [1:0] own_trans;
    logic       own_lock;
    port_idx_t  dp_port_q;
    logic       data_valid_q;

    ahb_mtx_arb_rr3 u_arb (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .ready       (HREADYMUXM),
        .req         ({sel_op2, sel_op1, sel_op0}),
        .trans       ({trans_op2, trans_op1, trans_op0}),
        .burst       ({burst_op2, burst_op1, burst_op0}),
        .mastlock    ({mastlock_op2, mastlock_op1, mastlock_op0}),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Address-phase mux; follows grant even when parked so HADDRM stays stable.
    always_comb begin
        own_sel   = sel_op0;
        own_trans = trans_op0;
        own_lock  = mastlock_op0;
        HADDRM    = addr_op0;
        HWRITEM   = write_op0;
        HSIZEM    = size_op0;
        HBURSTM   = burst_op0;
        HPROTM    = prot_op0;
        case (grant)
            2'd1: begin
                own_sel   = sel_op1;
                own_trans = trans_op1;
                own_lock  = mastlock_op1;
                HADDRM    = addr_op1;
                HWRITEM   = write_op1;
                HSIZEM    = size_op1;
                HBURSTM   = burst_op1;
                HPROTM    = prot_op1;
            end
            2'd2: begin
                own_sel   = sel_op2;
                own_trans = trans_op2;
                own_lock  = mastlock_op2;
                HADDRM    = addr_op2;
                HWRITEM   = write_op2;
                HSIZEM    = size_op2;
                HBURSTM   = burst_op2;
                HPROTM    = prot_op2;
            end
            default: ;
        endcase
    end

    assign HSELM      = grant_valid & own_sel;
    assign HTRANSM    = HSELM ? own_trans : TransIdle;
    assign HMASTLOCKM = HSELM & own_lock;
    assign HMASTERM   = {{(MasterIdW - PortIdxW){1'b0}}, grant};

    assign active_op0 = grant_valid & (grant == 2'd0) & sel_op0;
    assign active_op1 = grant_valid & (grant == 2'd1) & sel_op1;
    assign active_op2 = grant_valid & (grant == 2'd2) & sel_op2;

    // Data-phase registers only advance on an accepted cycle, so a grant change
    // during wait states never disturbs the in-flight transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_port_q    <= '0;
            data_valid_q <= 1'b0;
        end else if (HREADYMUXM) begin
            dp_port_q    <= grant;
            data_valid_q <= HSELM & HTRANSM[1];
        end
    end

    always_comb begin
        HWDATAM = '0;
        if (data_valid_q) begin
            case (dp_port_q)
                2'd1:    HWDATAM = wdata_op1;
                2'd2:    HWDATAM = wdata_op2;
                default: HWDATAM = wdata_op0;
            endcase
        end
    end

    assign HREADYMUXM = data_valid_q ? HREADYOUTM : 1'b1;

endmodule

// File: tb/tb_ahb_mtx_out_stage3.sv
// ---------------------------------------------------------------------------
// tb_ahb_mtx_out_stage3
// Directed scenarios plus a randomized run checked against a cycle-level
// reference model of the output stage.
// ---------------------------------------------------------------------------
module tb_ahb_mtx_out_stage3;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        sel   [3];
    logic [31:0] addr  [3];
    logic [1:0]  trans [3];
    logic        write [3];
    logic [2:0]  size  [3];
    logic [2:0]  burst [3];
    logic [3:0]  prot  [3];
    logic        lock  [3];
    logic [31:0] wdata [3];
    logic        HREADYOUTM;

    logic [2:0]  active;
    logic        HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
    logic [31:0] HADDRM, HWDATAM;
    logic [1:0]  HTRANSM;
    logic [2:0]  HSIZEM, HBURSTM;
    logic [3:0]  HPROTM, HMASTERM;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state: owner, last granted port (lowest priority) and data phase.
    bit          m_valid;
    int          m_owner;
    int          m_last;
    int          m_dp;
    bit          m_dv;
    logic        exp_sel, exp_lock, exp_rdy;
    logic [1:0]  exp_trans;
    logic [3:0]  exp_master;
    logic [2:0]  exp_active;
    logic [31:0] exp_addr, exp_wdata;
    logic [10:0] exp_ctrl;

    always #5 HCLK = ~HCLK;

    ahb_mtx_out_stage3 dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .sel_op0      (sel[0]),
        .sel_op1      (sel[1]),
        .sel_op2      (sel[2]),
        .addr_op0     (addr[0]),
        .addr_op1     (addr[1]),
        .addr_op2     (addr[2]),
        .trans_op0    (trans[0]),
        .trans_op1    (trans[1]),
        .trans_op2    (trans[2]),
        .write_op0    (write[0]),
        .write_op1    (write[1]),
        .write_op2    (write[2]),
        .size_op0     (size[0]),
        .size_op1     (size[1]),
        .size_op2     (size[2]),
        .burst_op0    (burst[0]),
        .burst_op1    (burst[1]),
        .burst_op2    (burst[2]),
        .prot_op0     (prot[0]),
        .prot_op1     (prot[1]),
        .prot_op2     (prot[2]),
        .mastlock_op0 (lock[0]),
        .mastlock_op1 (lock[1]),
        .mastlock_op2 (lock[2]),
        .wdata_op0    (wdata[0]),
        .wdata_op1    (wdata[1]),
        .wdata_op2    (wdata[2]),
        .active_op0   (active[0]),
        .active_op1   (active[1]),
        .active_op2   (active[2]),
        .HSELM        (HSELM),
        .HADDRM       (HADDRM),
        .HTRANSM      (HTRANSM),
        .HWRITEM      (HWRITEM),
        .HSIZEM       (HSIZEM),
        .HBURSTM      (HBURSTM),
        .HPROTM       (HPROTM),
        .HMASTERM     (HMASTERM),
        .HMASTLOCKM   (HMASTLOCKM),
        .HWDATAM      (HWDATAM),
        .HREADYMUXM   (HREADYMUXM),
        .HREADYOUTM   (HREADYOUTM)
    );

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) begin
            sel[i]   = 1'b0;
            addr[i]  = 32'h1000_0000 * (i + 1);
            trans[i] = IDLE;
            write[i] = 1'b0;
            size[i]  = 3'd2;
            burst[i] = 3'd0;
            prot[i]  = 4'h3;
            lock[i]  = 1'b0;
            wdata[i] = 32'hD000_0000 + i;
        end
        HREADYOUTM = 1'b1;
    endtask

    // Leaves the bench at posedge+1 with reset released and all ports idle.
    task automatic do_reset();
        HRESETn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        m_valid = 1'b0; m_owner = 0; m_last = 2; m_dp = 0; m_dv = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    // Model outputs for the current cycle from the spec's mux rules.
    task automatic model_outputs();
        exp_sel    = m_valid && sel[m_owner];
        exp_trans  = exp_sel ? trans[m_owner] : IDLE;
        exp_lock   = exp_sel && lock[m_owner];
        exp_addr   = addr[m_owner];
        exp_ctrl   = {write[m_owner], size[m_owner], burst[m_owner], prot[m_owner]};
        exp_master = 4'(m_owner);
        for (int n = 0; n < 3; n++) exp_active[n] = m_valid && (m_owner == n) && sel[n];
        exp_rdy    = m_dv ? HREADYOUTM : 1'b1;
        exp_wdata  = m_dv ? wdata[m_dp] : 32'h0;
    endtask

    // Model clock edge; call after model_outputs while inputs are still stable.
    task automatic model_edge();
        bit keep;
        bit found;
        int p;
        if (!exp_rdy) return;
        m_dp = m_owner;
        m_dv = exp_sel && (exp_trans == NONSEQ || exp_trans == SEQ);
        keep = m_valid && (trans[m_owner] == SEQ || trans[m_owner] == BUSY ||
                           (trans[m_owner] == NONSEQ && burst[m_owner] != 3'd0) ||
                           lock[m_owner]);
        found = 1'b0;
        if (!keep) begin
            for (int k = 1; k <= 3; k++) begin
                p = (m_last + k) % 3;
                if (!found && sel[p]) begin
                    found = 1'b1;
                    m_owner = p;
                    m_last = p;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            sel[i] = 1'b1; trans[i] = NONSEQ; lock[i] = 1'b1;
        end
        HREADYOUTM = 1'b0;
        repeat (2) @(posedge HCLK);
        #2;
        n_vec++;
        if ({HSELM, HTRANSM, HMASTLOCKM, active, HREADYMUXM, HMASTERM} !== 12'b0_00_0_000_1_0000) begin
            n_err++;
            $display("FAIL reset_outputs: got sel=%b trans=%b lock=%b act=%b rdy=%b mst=%0d want 0 00 0 000 1 0",
                     HSELM, HTRANSM, HMASTLOCKM, active, HREADYMUXM, HMASTERM);
        end
        n_vec++;
        if (HWDATAM !== 32'h0) begin
            n_err++;
            $display("FAIL reset_hwdata: got %h want 0", HWDATAM);
        end
    endtask

    task automatic test_single();
        do_reset();
        sel[1] = 1'b1; trans[1] = NONSEQ; addr[1] = 32'h4003_0000;
        @(negedge HCLK);
        n_vec++;
        if ({HSELM, active[1]} !== 2'b00) begin
            n_err++;
            $display("FAIL single_wait: got sel=%b act1=%b want 0 0", HSELM, active[1]);
        end
        next_cycle();
        @(negedge HCLK);
        n_vec++;
        if ({HSELM, HTRANSM, HMASTERM, active} !== {1'b1, NONSEQ, 4'd1, 3'b010}) begin
            n_err++;
            $display("FAIL single_grant: got sel=%b trans=%b mst=%0d act=%b want 1 10 1 010",
                     HSELM, HTRANSM, HMASTERM, active);
        end
        n_vec++;
        if (HADDRM !== 32'h4003_0000) begin
            n_err++;
            $display("FAIL single_addr: got %h want 40030000", HADDRM);
        end
        next_cycle();
        sel[1] = 1'b0; trans[1] = IDLE; HREADYOUTM = 1'b0;
        @(negedge HCLK);
        n_vec++;
        if ({HREADYMUXM, HSELM, HMASTERM} !== {1'b0, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL single_dphase_wait: got rdy=%b sel=%b mst=%0d want 0 0 1",
                     HREADYMUXM, HSELM, HMASTERM);
        end
        HREADYOUTM = 1'b1;
        #1;
        n_vec++;
        if (HREADYMUXM !== 1'b1) begin
            n_err++;
            $display("FAIL single_dphase_ready: got %b want 1", HREADYMUXM);
        end
        next_cycle();
        HREADYOUTM = 1'b0;
        @(negedge HCLK);
        n_vec++;
        if ({HREADYMUXM, HTRANSM, HMASTERM} !== {1'b1, IDLE, 4'd1}) begin
            n_err++;
            $display("FAIL single_park: got rdy=%b trans=%b mst=%0d want 1 00 1",
                     HREADYMUXM, HTRANSM, HMASTERM);
        end
    endtask

    task automatic test_round_robin();
        int exp_g [4] = '{0, 1, 2, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sel[i] = 1'b1; trans[i] = NONSEQ; wdata[i] = 32'hA0A0_0000 + i;
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge HCLK);
            n_vec++;
            if ({HSELM, HMASTERM, active} !== {1'b1, 4'(exp_g[k]), 3'(1 << exp_g[k])}) begin
                n_err++;
                $display("FAIL rr_grant%0d: got sel=%b mst=%0d act=%b want 1 %0d",
                         k, HSELM, HMASTERM, active, exp_g[k]);
            end
            if (k > 0) begin
                n_vec++;
                if (HWDATAM !== wdata[exp_g[k-1]]) begin
                    n_err++;
                    $display("FAIL rr_wdata%0d: got %h want %h", k, HWDATAM, wdata[exp_g[k-1]]);
                end
            end
        end
    endtask

    task automatic test_burst();
        logic [1:0] et;
        do_reset();
        sel[0] = 1'b1; trans[0] = NONSEQ; burst[0] = 3'b011; addr[0] = 32'h2000_0000;
        sel[2] = 1'b1; trans[2] = NONSEQ;
        next_cycle();
        for (int beat = 0; beat < 4; beat++) begin
            et = (beat == 0) ? NONSEQ : SEQ;
            @(negedge HCLK);
            n_vec++;
            if ({HSELM, HMASTERM, HTRANSM, active[2]} !== {1'b1, 4'd0, et, 1'b0}) begin
                n_err++;
                $display("FAIL burst_beat%0d: got sel=%b mst=%0d trans=%b act2=%b want 1 0 %b 0",
                         beat, HSELM, HMASTERM, HTRANSM, active[2], et);
            end
            next_cycle();
            trans[0] = SEQ;
            addr[0]  = addr[0] + 32'd4;
        end
        sel[0] = 1'b0; trans[0] = IDLE;
        @(negedge HCLK);
        n_vec++;
        if ({HMASTERM, active[2]} !== {4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL burst_tail: got mst=%0d act2=%b want 0 0", HMASTERM, active[2]);
        end
        next_cycle();
        @(negedge HCLK);
        n_vec++;
        if ({HSELM, HMASTERM, active} !== {1'b1, 4'd2, 3'b100}) begin
            n_err++;
            $display("FAIL burst_handover: got sel=%b mst=%0d act=%b want 1 2 100",
                     HSELM, HMASTERM, active);
        end
    endtask

    task automatic test_lock();
        do_reset();
        sel[1] = 1'b1; trans[1] = NONSEQ; write[1] = 1'b1; lock[1] = 1'b1;
        next_cycle();
        sel[0] = 1'b1; trans[0] = NONSEQ;
        for (int c = 0; c < 4; c++) begin
            trans[1] = (c < 2) ? NONSEQ : IDLE;
            lock[1]  = (c < 3);
            @(negedge HCLK);
            n_vec++;
            if ({HMASTERM, HMASTLOCKM, active[0]} !== {4'd1, (c < 3), 1'b0}) begin
                n_err++;
                $display("FAIL lock_hold%0d: got mst=%0d lock=%b act0=%b want 1 %b 0",
                         c, HMASTERM, HMASTLOCKM, active[0], (c < 3));
            end
            next_cycle();
        end
        @(negedge HCLK);
        n_vec++;
        if ({HMASTERM, HMASTLOCKM, active} !== {4'd0, 1'b0, 3'b001}) begin
            n_err++;
            $display("FAIL lock_release: got mst=%0d lock=%b act=%b want 0 0 001",
                     HMASTERM, HMASTLOCKM, active);
        end
    endtask

    // Port 2 write enters its data phase while port 0 takes the address phase.
    task automatic start_wait_scenario();
        do_reset();
        sel[2] = 1'b1; trans[2] = NONSEQ; write[2] = 1'b1; wdata[2] = 32'h5A5A_0002;
        wdata[0] = 32'h0000_00A0;
        next_cycle();
        sel[0] = 1'b1; trans[0] = NONSEQ; write[0] = 1'b1;
        next_cycle();
        sel[2] = 1'b0; trans[2] = IDLE; HREADYOUTM = 1'b0;
    endtask

    task automatic test_wait_state();
        start_wait_scenario();
        for (int w = 0; w < 3; w++) begin
            @(negedge HCLK);
            n_vec++;
            if ({HWDATAM, HREADYMUXM, HMASTERM, HSELM} !== {32'h5A5A_0002, 1'b0, 4'd0, 1'b1}) begin
                n_err++;
                $display("FAIL wait%0d: got wd=%h rdy=%b mst=%0d sel=%b want 5a5a0002 0 0 1",
                         w, HWDATAM, HREADYMUXM, HMASTERM, HSELM);
            end
            next_cycle();
        end
        HREADYOUTM = 1'b1;
        @(negedge HCLK);
        n_vec++;
        if ({HWDATAM, HREADYMUXM} !== {32'h5A5A_0002, 1'b1}) begin
            n_err++;
            $display("FAIL wait_done: got wd=%h rdy=%b want 5a5a0002 1", HWDATAM, HREADYMUXM);
        end
        next_cycle();
        sel[0] = 1'b0; trans[0] = IDLE;
        @(negedge HCLK);
        n_vec++;
        if (HWDATAM !== 32'h0000_00A0) begin
            n_err++;
            $display("FAIL wait_next_dphase: got %h want 000000a0", HWDATAM);
        end
    endtask

    task automatic test_reset_mid();
        start_wait_scenario();
        @(negedge HCLK);
        n_vec++;
        if (HREADYMUXM !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_pre: got rdy=%b want 0", HREADYMUXM);
        end
        #1 HRESETn = 1'b0;
        #1;
        n_vec++;
        if ({HSELM, HTRANSM, HMASTLOCKM, active, HREADYMUXM, HMASTERM, HWDATAM} !==
            {12'b0_00_0_000_1_0000, 32'h0}) begin
            n_err++;
            $display("FAIL rstmid_async: got sel=%b trans=%b act=%b rdy=%b mst=%0d wd=%h",
                     HSELM, HTRANSM, active, HREADYMUXM, HMASTERM, HWDATAM);
        end
        next_cycle();
        HRESETn = 1'b1;
        @(negedge HCLK);
        n_vec++;
        if ({HSELM, HTRANSM, HMASTLOCKM, active, HREADYMUXM, HMASTERM, HWDATAM} !==
            {12'b0_00_0_000_1_0000, 32'h0}) begin
            n_err++;
            $display("FAIL rstmid_after: got sel=%b trans=%b act=%b rdy=%b mst=%0d wd=%h",
                     HSELM, HTRANSM, active, HREADYMUXM, HMASTERM, HWDATAM);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                sel[i]   = ($urandom_range(0, 9) < 6);
                trans[i] = 2'($urandom_range(0, 3));
                lock[i]  = ($urandom_range(0, 7) == 0);
                burst[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                write[i] = 1'($urandom_range(0, 1));
                size[i]  = 3'($urandom_range(0, 2));
                prot[i]  = 4'($urandom_range(0, 15));
                addr[i]  = $urandom;
                wdata[i] = $urandom;
            end
            HREADYOUTM = ($urandom_range(0, 3) != 0);
            @(negedge HCLK);
            model_outputs();
            n_vec++;
            if ({HSELM, HTRANSM, HMASTLOCKM, HMASTERM, active, HREADYMUXM} !==
                {exp_sel, exp_trans, exp_lock, exp_master, exp_active, exp_rdy}) begin
                n_err++;
                $display("FAIL rand%0d_ctl: got sel=%b tr=%b lk=%b mst=%0d act=%b rdy=%b want %b %b %b %0d %b %b",
                         c, HSELM, HTRANSM, HMASTLOCKM, HMASTERM, active, HREADYMUXM,
                         exp_sel, exp_trans, exp_lock, exp_master, exp_active, exp_rdy);
            end
            n_vec++;
            if ({HADDRM, HWRITEM, HSIZEM, HBURSTM, HPROTM} !== {exp_addr, exp_ctrl}) begin
                n_err++;
                $display("FAIL rand%0d_addr: got %h/%h want %h/%h", c, HADDRM,
                         {HWRITEM, HSIZEM, HBURSTM, HPROTM}, exp_addr, exp_ctrl);
            end
            n_vec++;
            if (HWDATAM !== exp_wdata) begin
                n_err++;
                $display("FAIL rand%0d_wdata: got %h want %h", c, HWDATAM, exp_wdata);
            end
            model_edge();
            next_cycle();
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_lock();
        test_wait_state();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
